// File: rtl/counter_pkg.sv
// Shared types and helpers for the digit sequencer.
//   state_t : sequencer FSM states
//   BCD_MAX : largest legal BCD nibble value
//   is_bcd  : 1 when a nibble is a legal decimal digit
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with synchronous clear and a combinational wrap flag.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   en    : advance the count this cycle
//   clr   : synchronous clear, wins over en
//   count : current count, 0..N-1
//   wrap  : en && count == N-1 (count returns to 0 at the next edge)
module mod_n_counter #(
  parameter  int N  = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/phone_digit_sequencer.sv
// Captures a packed BCD number and presents it one digit at a time, most
// significant digit first, each digit held for HOLD_CYCLES unpaused cycles.
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   start       : begin a sequence (honoured only in IDLE)
//   number_in   : packed BCD, digit 0 in the top nibble
//   pause       : freeze sequencing while high in RUN
//   abort       : end a running sequence without done
//   busy        : high while a sequence is running
//   digit_valid : digit is being presented and advancing
//   digit       : current BCD digit
//   digit_idx   : index of the current digit
//   done        : one-cycle pulse after the last digit
//   error       : one-cycle pulse after a start with a non-BCD nibble
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; digit/digit_idx parked at 0
// RUN   | presenting digits; pause freezes, abort returns to IDLE
// DONE  | one-cycle done pulse, start ignored, then IDLE
module phone_digit_sequencer
  import counter_pkg::*;
#(
  parameter  int NUM_DIGITS  = 10,
  parameter  int HOLD_CYCLES = 4,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] number_in,
  input  logic                    pause,
  input  logic                    abort,
  output logic                    busy,
  output logic                    digit_valid,
  output logic [3:0]              digit,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    done,
  output logic                    error
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic              cnt_en;
  logic              cnt_clr;
  logic [HOLD_W-1:0] hold_count;
  logic              hold_wrap;
  logic [IDX_W-1:0]  idx_count;
  logic              idx_wrap;
  logic [IDX_W-1:0]  next_idx;
  logic [3:0]        next_digit;
  logic              bcd_ok;
  logic              unused_hold;

  // Counters only run in RUN on unpaused, non-aborted cycles. They are held
  // at zero everywhere else, so a fresh start always begins at digit 0.
  assign cnt_en  = (state == RUN) && !abort && !pause;
  assign cnt_clr = (state != RUN) || abort;

  mod_n_counter #(.N(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (hold_count),
    .wrap  (hold_wrap)
  );

  mod_n_counter #(.N(NUM_DIGITS)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .en    (hold_wrap),
    .clr   (cnt_clr),
    .count (idx_count),
    .wrap  (idx_wrap)
  );

  // The hold phase is consumed only through its wrap flag.
  assign unused_hold = ^hold_count;

  assign digit_idx = idx_count;
  assign next_idx  = idx_count + 1'b1;

  // Digit that becomes current when the hold counter wraps.
  always_comb begin
    next_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (next_idx == IDX_W'(i)) begin
        next_digit = shadow[4*(NUM_DIGITS-1-i) +: 4];
      end
    end
  end

  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(number_in[4*i +: 4])) begin
        bcd_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow      <= '0;
      busy        <= 1'b0;
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (bcd_ok) begin
              shadow      <= number_in;
              digit       <= number_in[4*NUM_DIGITS-1 -: 4];
              busy        <= 1'b1;
              digit_valid <= 1'b1;
              state       <= RUN;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy        <= 1'b0;
            digit_valid <= 1'b0;
            digit       <= 4'd0;
            state       <= IDLE;
          end else if (pause) begin
            digit_valid <= 1'b0;
          end else if (idx_wrap) begin
            busy        <= 1'b0;
            digit_valid <= 1'b0;
            digit       <= 4'd0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            digit_valid <= 1'b1;
            if (hold_wrap) begin
              digit <= next_digit;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phone_digit_sequencer.sv
module tb_phone_digit_sequencer;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        abort = 1'b0;
  logic [39:0] number_in = '0;

  logic       busy4, valid4, done4, err4;
  logic [3:0] dig4, idx4;
  logic       busy1, valid1, done1, err1;
  logic [3:0] dig1, idx1;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int base = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  phone_digit_sequencer #(.NUM_DIGITS(N), .HOLD_CYCLES(4)) u_h4 (
    .clk(clk), .rst(rst), .start(start), .number_in(number_in),
    .pause(pause), .abort(abort), .busy(busy4), .digit_valid(valid4),
    .digit(dig4), .digit_idx(idx4), .done(done4), .error(err4)
  );

  phone_digit_sequencer #(.NUM_DIGITS(N), .HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .rst(rst), .start(start), .number_in(number_in),
    .pause(pause), .abort(abort), .busy(busy1), .digit_valid(valid1),
    .digit(dig1), .digit_idx(idx1), .done(done1), .error(err1)
  );

  // Behavioural model: p counts unpaused RUN edges since the accepting edge;
  // the current digit index is simply p / hold.
  int          hold_of [2] = '{4, 1};
  int          m_state [2] = '{0, 0};   // 0 idle, 1 running, 2 finished
  int          m_p     [2] = '{0, 0};
  logic [39:0] m_sh    [2] = '{40'd0, 40'd0};
  logic        m_busy  [2] = '{1'b0, 1'b0};
  logic        m_valid [2] = '{1'b0, 1'b0};
  logic        m_done  [2] = '{1'b0, 1'b0};
  logic        m_err   [2] = '{1'b0, 1'b0};
  logic [3:0]  m_digit [2] = '{4'd0, 4'd0};
  int          m_idx   [2] = '{0, 0};

  function automatic bit all_bcd(input logic [39:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int u = 0; u < 2; u++) begin
      automatic int          st = m_state[u];
      automatic int          p  = m_p[u];
      automatic logic [39:0] sh = m_sh[u];
      automatic logic        vl = 1'b0;
      automatic logic        dn = 1'b0;
      automatic logic        er = 1'b0;
      automatic int          ix = 0;
      automatic logic [3:0]  dg = 4'd0;
      if (!rst) begin
        st = 0; p = 0; sh = '0;
      end else begin
        case (st)
          0: if (start) begin
               if (!all_bcd(number_in)) er = 1'b1;
               else begin sh = number_in; p = 0; st = 1; vl = 1'b1; end
             end
          1: if (abort) st = 0;
             else if (!pause) begin
               p = p + 1;
               if (p == N * hold_of[u]) begin st = 2; dn = 1'b1; end
               else vl = 1'b1;
             end
          default: st = 0;
        endcase
      end
      if (st == 1) begin
        ix = p / hold_of[u];
        dg = sh[4*(N-1-ix) +: 4];
      end
      m_state[u] <= st;
      m_p[u]     <= p;
      m_sh[u]    <= sh;
      m_busy[u]  <= (st == 1);
      m_valid[u] <= vl;
      m_done[u]  <= dn;
      m_err[u]   <= er;
      m_digit[u] <= dg;
      m_idx[u]   <= ix;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy_h4",  32'(busy4),  32'(m_busy[0]));
      chk("valid_h4", 32'(valid4), 32'(m_valid[0]));
      chk("digit_h4", 32'(dig4),   32'(m_digit[0]));
      chk("idx_h4",   32'(idx4),   32'(m_idx[0]));
      chk("done_h4",  32'(done4),  32'(m_done[0]));
      chk("error_h4", 32'(err4),   32'(m_err[0]));
      chk("busy_h1",  32'(busy1),  32'(m_busy[1]));
      chk("valid_h1", 32'(valid1), 32'(m_valid[1]));
      chk("digit_h1", 32'(dig1),   32'(m_digit[1]));
      chk("idx_h1",   32'(idx1),   32'(m_idx[1]));
      chk("done_h1",  32'(done1),  32'(m_done[1]));
      chk("error_h1", 32'(err1),   32'(m_err[1]));
      chk("err_done_excl", 32'(err4 & done4), 32'd0);
    end
  end

  task automatic launch(input logic [39:0] num);
    number_in = num;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = cyc_cnt;
  endtask

  task automatic wait_to(input int m);
    while (cyc_cnt < base + m) @(negedge clk);
  endtask

  function automatic logic [39:0] rand_number();
    logic [39:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) begin
      int pos;
      pos = $urandom_range(0, N - 1);
      v[4*pos +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_rst_busy",  32'(busy4),  32'd0);
    chk("lit_rst_digit", 32'(dig4),   32'd0);
    chk("lit_rst_idx",   32'(idx4),   32'd0);
    rst = 1'b1;
    @(negedge clk);

    // normal sequence
    launch(40'h9876543210);
    chk("lit_norm_busy0",  32'(busy4),  32'd1);
    chk("lit_norm_valid0", 32'(valid4), 32'd1);
    chk("lit_norm_dig0",   32'(dig4),   32'd9);
    chk("lit_h1_dig0",     32'(dig1),   32'd9);
    wait_to(3);  chk("lit_norm_dig3",  32'(dig4), 32'd9);
    wait_to(4);  chk("lit_norm_dig4",  32'(dig4), 32'd8);
                 chk("lit_norm_idx4",  32'(idx4), 32'd1);
    wait_to(5);  chk("lit_h1_dig5",    32'(dig1), 32'd4);
                 chk("lit_h1_idx5",    32'(idx1), 32'd5);
    wait_to(10); chk("lit_h1_done10",  32'(done1), 32'd1);
    wait_to(39); chk("lit_norm_dig39", 32'(dig4), 32'd0);
                 chk("lit_norm_idx39", 32'(idx4), 32'd9);
    wait_to(40); chk("lit_norm_done40", 32'(done4), 32'd1);
                 chk("lit_norm_busy40", 32'(busy4), 32'd0);
    wait_to(41); chk("lit_norm_done41", 32'(done4), 32'd0);

    // rejected start
    launch(40'h98765A3210);
    chk("lit_inv_err",   32'(err4),  32'd1);
    chk("lit_inv_busy",  32'(busy4), 32'd0);
    chk("lit_inv_digit", 32'(dig4),  32'd0);
    wait_to(1); chk("lit_inv_err_clr", 32'(err4), 32'd0);
    wait_to(2);

    // pause during digit 2
    launch(40'h9876543210);
    wait_to(8);  pause = 1'b1;
    wait_to(9);  chk("lit_pause_dig",   32'(dig4),   32'd7);
                 chk("lit_pause_valid", 32'(valid4), 32'd0);
                 chk("lit_pause_busy",  32'(busy4),  32'd1);
    wait_to(11); pause = 1'b0;
    wait_to(14); chk("lit_pause_dig14", 32'(dig4), 32'd7);
    wait_to(15); chk("lit_pause_dig15", 32'(dig4), 32'd6);
    wait_to(42); chk("lit_pause_done42", 32'(done4), 32'd0);
    wait_to(43); chk("lit_pause_done43", 32'(done4), 32'd1);
    wait_to(44);

    // abort during digit 6, then immediate restart
    launch(40'h9876543210);
    wait_to(24); chk("lit_abort_dig24", 32'(dig4), 32'd3);
                 abort = 1'b1;
    wait_to(25); chk("lit_abort_busy", 32'(busy4), 32'd0);
                 abort = 1'b0;
    launch(40'h0123456789);
    chk("lit_restart_dig0", 32'(dig4), 32'd0);
    wait_to(4);  chk("lit_restart_dig4", 32'(dig4), 32'd1);
    wait_to(36); chk("lit_restart_dig36", 32'(dig4), 32'd9);
    wait_to(40); chk("lit_restart_done", 32'(done4), 32'd1);
    wait_to(42);

    // start ignored in RUN and DONE (H=1 instance)
    launch(40'h1357913579);
    wait_to(2);  start = 1'b1;
    wait_to(3);  start = 1'b0;
                 chk("lit_h1_dig3", 32'(dig1), 32'd7);
    wait_to(4);  chk("lit_h1_dig4", 32'(dig1), 32'd9);
                 chk("lit_h4_dig4", 32'(dig4), 32'd3);
    wait_to(9);  start = 1'b1;
    wait_to(10); start = 1'b0;
                 chk("lit_h1_done", 32'(done1), 32'd1);
                 chk("lit_h4_dig10", 32'(dig4), 32'd5);
    wait_to(11); chk("lit_h1_idle", 32'(busy1), 32'd0);
    wait_to(41);

    // asynchronous reset at digit 5
    launch(40'h9876543210);
    wait_to(21);
    #1 rst = 1'b0;
    #1;
    chk("lit_arst_busy",  32'(busy4),  32'd0);
    chk("lit_arst_valid", 32'(valid4), 32'd0);
    chk("lit_arst_digit", 32'(dig4),   32'd0);
    chk("lit_arst_idx",   32'(idx4),   32'd0);
    chk("lit_arst_done",  32'(done4),  32'd0);
    chk("lit_arst_err",   32'(err4),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("lit_arst_after", 32'(busy4), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      pause     = ($urandom_range(0, 5) == 0);
      abort     = ($urandom_range(0, 63) == 0);
      number_in = rand_number();
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phone_digit_sequencer.md
# phone_digit_sequencer

Controller that sequences a mod-10 digit stream: it captures a packed multi-digit BCD number and drives it out one digit at a time, each digit held for a programmable number of cycles, with a start/busy/done handshake. It sits between the control logic that supplies the number and the display/counter datapath that consumes `digit`. It replaces free-running mod-10 counting with a loaded, pausable, abortable sequence.

## Interface
- `NUM_DIGITS`, 10: digits per sequence; ≥2.
- `HOLD_CYCLES`, 4: cycles each digit is presented; ≥1.
- `IDX_W`, `$clog2(NUM_DIGITS)`: derived, not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `number_in`  in  4*NUM_DIGITS  packed BCD; digit 0 = MS nibble `[4*NUM_DIGITS-1 -: 4]`.
- `pause`  in  1  freezes sequencing while high in RUN.
- `abort`  in  1  terminates a running sequence.
- `busy`  out  1  high in RUN.
- `digit_valid`  out  1  `digit` is valid and advancing.
- `digit`  out  4  current BCD digit.
- `digit_idx`  out  IDX_W  index of current digit.
- `done`  out  1  one-cycle pulse after last digit completes.
- `error`  out  1  one-cycle pulse: rejected start (non-BCD nibble).

## Operation
- FSM states IDLE, RUN, DONE. All outputs registered.
- IDLE: on `start`=1:
  - If any nibble of `number_in` > 9: pulse `error`, remain IDLE, nothing captured.
  - Otherwise: capture `number_in` into the shadow register, `digit_idx`←0, hold counter←0, go RUN.
- RUN, priority abort > pause > advance:
  - `abort`=1: go IDLE next edge; no `done` pulse; `digit_valid`, `busy` low.
  - `pause`=1: hold counter and index frozen; `digit` keeps its value; `digit_valid` low for the paused cycles; `busy` stays high.
  - Otherwise the hold counter increments. At HOLD_CYCLES-1 it wraps to 0 and the index advances.
  - At the wrap of index NUM_DIGITS-1, go DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, `digit_valid`=0, then IDLE. `start` in DONE is ignored.
- `start` in RUN is ignored. `number_in` changes after capture have no effect.
- `error` and `done` are never high together.
- `abort` in IDLE/DONE has no effect.
- Reset values: state IDLE; `busy`, `digit_valid`, `done`, `error` = 0; `digit`=0; `digit_idx`=0; shadow register = 0. Reset asserted mid-RUN returns to these values immediately, without waiting for a clock edge.

## Timing
- `start` accepted at edge k: `busy`=1, `digit_valid`=1, `digit`=digit 0 from edge k through k+HOLD_CYCLES.
- Digit i is presented for HOLD_CYCLES unpaused cycles, plus any paused cycles.
- Unpaused sequence length is NUM_DIGITS*HOLD_CYCLES cycles. `done` goes high at edge k+NUM_DIGITS*HOLD_CYCLES for one cycle. The earliest next `start` is accepted one cycle later.
- HOLD_CYCLES=1: a new digit every cycle, with no bubble between digits.
- `error` is asserted in the cycle after the rejected `start` edge.
- `abort` at edge m: `busy`=0 from edge m.

## Structure
- Package `counter_pkg`:
  - state enum (IDLE, RUN, DONE);
  - `BCD_MAX`=4'd9 constant;
  - function `is_bcd(nibble)`.
- Sub-module `mod_n_counter` (parameter N; ports `clk`, `rst`, `en`, `clr`, `count`, `wrap`), instantiated twice:
  - hold counter, N=HOLD_CYCLES;
  - digit index, N=NUM_DIGITS.
- `wrap` is combinational: `en && count==N-1`.

## Test plan
- Reset: `rst`=0 mid-RUN at digit 5 → all outputs 0 immediately; after release, IDLE with `busy`=0.
- Normal: `number_in`=40'h9876543210, HOLD_CYCLES=4, `start` pulse:
  - `digit` sequence 9,8,…,0, each exactly 4 cycles with `digit_valid`=1 and `digit_idx` 0..9;
  - `done` pulse at cycle 40, `busy`=0 in that cycle.
- Invalid: `number_in`=40'h98765A3210 with `start` → `error` pulse one cycle later; `busy` never rises; `digit`=0.
- Pause: `pause` high 3 cycles during digit 2 → `digit`=7 held, `digit_valid`=0 for those 3 cycles; `done` is delayed to cycle 43.
- Abort/restart: `abort` during digit 6 → `busy`=0 next edge, no `done`. Immediate `start` with 40'h0123456789 → digit sequence 0..9 from the new value.
- HOLD_CYCLES=1 build: 10 consecutive valid digits with no gaps; `done` at cycle 10; `start` during RUN and during DONE is ignored.
